// File: rtl/mem_access_stage_pkg.sv
// Shared types and control-bit indices for the MEM pipeline stage.
// Also holds the alignment rule used to suppress misaligned accesses.
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int LD_LB  = 0;
   localparam int LD_LH  = 1;
   localparam int LD_LW  = 2;
   localparam int LD_LBU = 3;
   localparam int LD_LHU = 4;

   localparam int ST_SB = 0;
   localparam int ST_SH = 1;
   localparam int ST_SW = 2;

   function automatic logic is_misaligned(input logic [4:0] loadcntrl,
                                          input logic [2:0] storecntrl,
                                          input logic [1:0] addr_lo);
      logic half_op;
      logic word_op;
      half_op = loadcntrl[LD_LH] | loadcntrl[LD_LHU] | storecntrl[ST_SH];
      word_op = loadcntrl[LD_LW] | storecntrl[ST_SW];
      return (half_op & addr_lo[0]) | (word_op & (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store byte enables / replicated write
// data, and load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [4:0]  loadcntrl,
   input  logic [2:0]  storecntrl,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  store_be,
   output logic [31:0] store_wdata,
   output logic [31:0] load_data
);

   logic [31:0] rdata_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      store_be    = 4'b0000;
      store_wdata = store_data;
      if (storecntrl[ST_SB]) begin
         store_be    = 4'b0001 << addr_lo;
         store_wdata = {4{store_data[7:0]}};
      end else if (storecntrl[ST_SH]) begin
         store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
         store_wdata = {2{store_data[15:0]}};
      end else if (storecntrl[ST_SW]) begin
         store_be    = 4'b1111;
      end
   end

   assign rdata_shift = rdata >> {addr_lo, 3'b000};
   assign ld_byte     = rdata_shift[7:0];
   assign ld_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_data = 32'h0;
      if (loadcntrl[LD_LB])       load_data = {{24{ld_byte[7]}}, ld_byte};
      else if (loadcntrl[LD_LH])  load_data = {{16{ld_half[15]}}, ld_half};
      else if (loadcntrl[LD_LW])  load_data = rdata;
      else if (loadcntrl[LD_LBU]) load_data = {24'h0, ld_byte};
      else if (loadcntrl[LD_LHU]) load_data = {16'h0, ld_half};
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to a variable-latency data port,
// stalls the pipe while waiting, and registers the MEM_WB writeback set.
//
// state | meaning
// IDLE  | issue this cycle's access; zero-wait acks complete here
// WAIT  | request held stable until ack or timeout
// DONE  | ack arrived under debug freeze; read data latched until dbg drops
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        dbg,
   input  logic        EX_MEM_memread,
   input  logic        EX_MEM_memwrite,
   input  logic        EX_MEM_regwrite,
   input  logic [4:0]  EX_MEM_rd,
   input  logic [31:0] EX_MEM_alures,
   input  logic [31:0] EX_MEM_dout_rs2,
   input  logic [4:0]  EX_MEM_loadcntrl,
   input  logic [2:0]  EX_MEM_storecntrl,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_hold,
   output logic        MEM_WB_regwrite,
   output logic [4:0]  MEM_WB_rd,
   output logic [31:0] WB_res,
   output logic        mem_misalign,
   output logic        mem_bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   mem_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        access, misalign, timeout, wb_update;
   logic        latch_req, latch_rdata;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data, ld_rdata;

   logic        iss_we;
   logic [31:0] iss_addr, iss_wdata;
   logic [3:0]  iss_be;

   logic        req_we_q;
   logic [31:0] req_addr_q, req_wdata_q, rdata_q;
   logic [3:0]  req_be_q;

   assign access   = EX_MEM_memread | EX_MEM_memwrite;
   assign misalign = is_misaligned(EX_MEM_loadcntrl, EX_MEM_storecntrl, EX_MEM_alures[1:0]);

   assign iss_we    = EX_MEM_memwrite;
   assign iss_addr  = {EX_MEM_alures[31:2], 2'b00};
   assign iss_be    = EX_MEM_memwrite ? st_be : 4'b1111;
   assign iss_wdata = EX_MEM_memwrite ? st_wdata : 32'h0;

   // Once DONE, the port has moved on; extract from the captured word instead.
   assign ld_rdata = (state_q == DONE) ? rdata_q : dmem_rdata;

   mem_lane_align u_lane_align (
      .addr_lo     (EX_MEM_alures[1:0]),
      .loadcntrl   (EX_MEM_loadcntrl),
      .storecntrl  (EX_MEM_storecntrl),
      .store_data  (EX_MEM_dout_rs2),
      .rdata       (ld_rdata),
      .store_be    (st_be),
      .store_wdata (st_wdata),
      .load_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = 32'h0;
      dmem_be     = 4'b0000;
      dmem_wdata  = 32'h0;
      mem_hold    = 1'b0;
      timeout     = 1'b0;
      latch_req   = 1'b0;
      latch_rdata = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req = access & ~misalign & ~dbg;
            if (dmem_req) begin
               dmem_we    = iss_we;
               dmem_addr  = iss_addr;
               dmem_be    = iss_be;
               dmem_wdata = iss_wdata;
               if (!dmem_ack) begin
                  mem_hold  = 1'b1;
                  latch_req = 1'b1;
                  cnt_d     = CNT_W'(TIMEOUT_CYCLES - 1);
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            dmem_req   = 1'b1;
            dmem_we    = req_we_q;
            dmem_addr  = req_addr_q;
            dmem_be    = req_be_q;
            dmem_wdata = req_wdata_q;
            if (dmem_ack) begin
               latch_rdata = dbg;
               state_d     = dbg ? DONE : IDLE;
            end else if (cnt_q == '0) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               mem_hold = 1'b1;
               cnt_d    = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (!dbg) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_update = ~dbg & ~mem_hold;

   always_ff @(posedge clk) begin
      if (Rst) begin
         req_we_q        <= 1'b0;
         req_addr_q      <= 32'h0;
         req_be_q        <= 4'b0000;
         req_wdata_q     <= 32'h0;
         rdata_q         <= 32'h0;
         MEM_WB_regwrite <= 1'b0;
         MEM_WB_rd       <= 5'd0;
         WB_res          <= 32'h0;
         mem_misalign    <= 1'b0;
         mem_bus_err     <= 1'b0;
      end else begin
         if (latch_req) begin
            req_we_q    <= iss_we;
            req_addr_q  <= iss_addr;
            req_be_q    <= iss_be;
            req_wdata_q <= iss_wdata;
         end
         if (latch_rdata) rdata_q <= dmem_rdata;
         mem_misalign <= wb_update & (state_q == IDLE) & access & misalign;
         mem_bus_err  <= timeout;
         if (wb_update) begin
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_regwrite <= EX_MEM_regwrite & ~misalign & ~timeout;
            WB_res          <= EX_MEM_memread ? ld_data : EX_MEM_alures;
         end
      end
   end

endmodule
